// File: rtl/nes_mem_arbiter_if.sv
// Bundle of the three requester ports and the external memory pins seen by nes_mem_arbiter.
// The slave modport is the arbiter's view. The master modport is the cart/memory side.
interface nes_mem_arbiter_if #(
  parameter int ADDR_W = 18
);
  logic              ppu_req;
  logic [ADDR_W-1:0] ppu_addr;
  logic              ppu_we;
  logic [7:0]        ppu_wdata;
  logic              ppu_ack;
  logic [7:0]        ppu_rdata;

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;

  logic              ldr_req;
  logic [ADDR_W-1:0] ldr_addr;
  logic              ldr_we;
  logic [7:0]        ldr_wdata;
  logic              ldr_ack;
  logic [7:0]        ldr_rdata;

  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy;

  modport slave (
    input  ppu_req, ppu_addr, ppu_we, ppu_wdata,
    output ppu_ack, ppu_rdata,
    input  cpu_req, cpu_addr, cpu_we, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  ldr_req, ldr_addr, ldr_we, ldr_wdata,
    output ldr_ack, ldr_rdata,
    output mem_ce, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output ppu_req, ppu_addr, ppu_we, ppu_wdata,
    input  ppu_ack, ppu_rdata,
    output cpu_req, cpu_addr, cpu_we, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output ldr_req, ldr_addr, ldr_we, ldr_wdata,
    input  ldr_ack, ldr_rdata,
    input  mem_ce, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/nes_mem_arbiter.sv
// Single-port external memory arbiter: PPU > CPU > loader, with the CPU forced in after
// MAX_STARVE back-to-back PPU grants. One access in flight. All outputs registered.
//
// state    | meaning
// S_IDLE   | arbitrate; on a winner, latch its request onto mem_* and raise mem_ce
// S_ACCESS | hold mem_* for WAIT_CYCLES cycles; on the last one capture read data and ack
// S_ACK    | ack pulse is visible; return to arbitration next cycle
module nes_mem_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2,
  parameter int MAX_STARVE  = 3
) (
  input logic              clk_25,
  input logic              rst,
  nes_mem_arbiter_if.slave bus
);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int STV_W = $clog2(MAX_STARVE + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(MAX_STARVE);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;
  typedef enum logic [1:0] {G_PPU, G_CPU, G_LDR} grant_t;

  state_t            state_q, state_d;
  grant_t            grant_q, grant_d, pick;
  logic              win;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              ce_q, ce_d, we_q, we_d, busy_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              ppu_ack_q, ppu_ack_d, cpu_ack_q, cpu_ack_d, ldr_ack_q, ldr_ack_d;
  logic [7:0]        ppu_rd_q, ppu_rd_d, cpu_rd_q, cpu_rd_d, ldr_rd_q, ldr_rd_d;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    ce_d      = ce_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ppu_ack_d = 1'b0;
    cpu_ack_d = 1'b0;
    ldr_ack_d = 1'b0;
    ppu_rd_d  = ppu_rd_q;
    cpu_rd_d  = cpu_rd_q;
    ldr_rd_d  = ldr_rd_q;
    pick      = G_PPU;
    win       = 1'b1;
    case (state_q)
      S_IDLE: begin
        ce_d = 1'b0;
        we_d = 1'b0;
        if (!bus.cpu_req) starve_d = '0;
        if (bus.cpu_req && starve_q == STV_MAX) pick = G_CPU;
        else if (bus.ppu_req)                   pick = G_PPU;
        else if (bus.cpu_req)                   pick = G_CPU;
        else if (bus.ldr_req)                   pick = G_LDR;
        else                                    win  = 1'b0;
        if (win) begin
          grant_d = pick;
          state_d = S_ACCESS;
          ce_d    = 1'b1;
          cnt_d   = CNT_LOAD;
          case (pick)
            G_PPU: begin
              addr_d  = bus.ppu_addr;
              we_d    = bus.ppu_we;
              wdata_d = bus.ppu_wdata;
              // PPU can only win over a waiting CPU below the limit, so this never overflows
              if (bus.cpu_req) starve_d = starve_q + 1'b1;
            end
            G_CPU: begin
              addr_d   = bus.cpu_addr;
              we_d     = bus.cpu_we;
              wdata_d  = bus.cpu_wdata;
              starve_d = '0;
            end
            default: begin
              addr_d  = bus.ldr_addr;
              we_d    = bus.ldr_we;
              wdata_d = bus.ldr_wdata;
            end
          endcase
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          ce_d    = 1'b0;
          we_d    = 1'b0;
          state_d = S_ACK;
          case (grant_q)
            G_PPU: begin
              ppu_ack_d = 1'b1;
              if (!we_q) ppu_rd_d = bus.mem_rdata;
            end
            G_CPU: begin
              cpu_ack_d = 1'b1;
              if (!we_q) cpu_rd_d = bus.mem_rdata;
            end
            default: begin
              ldr_ack_d = 1'b1;
              if (!we_q) ldr_rd_d = bus.mem_rdata;
            end
          endcase
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= G_PPU;
      cnt_q     <= '0;
      starve_q  <= '0;
      ce_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ppu_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      ldr_ack_q <= 1'b0;
      ppu_rd_q  <= '0;
      cpu_rd_q  <= '0;
      ldr_rd_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      ce_q      <= ce_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ppu_ack_q <= ppu_ack_d;
      cpu_ack_q <= cpu_ack_d;
      ldr_ack_q <= ldr_ack_d;
      ppu_rd_q  <= ppu_rd_d;
      cpu_rd_q  <= cpu_rd_d;
      ldr_rd_q  <= ldr_rd_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign bus.mem_ce    = ce_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.ppu_ack   = ppu_ack_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.ldr_ack   = ldr_ack_q;
  assign bus.ppu_rdata = ppu_rd_q;
  assign bus.cpu_rdata = cpu_rd_q;
  assign bus.ldr_rdata = ldr_rd_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Bench for nes_mem_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level timing/priority model and a reference memory image.
module tb_nes_mem_arbiter;
  localparam int ADDR_W = 18;
  localparam int WAIT   = 2;
  localparam int MAXS   = 3;

  logic clk_25 = 1'b0;
  logic rst    = 1'b1;
  always #20 clk_25 = ~clk_25;

  nes_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  nes_mem_arbiter #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT), .MAX_STARVE(MAXS)) dut (
    .clk_25(clk_25),
    .rst   (rst),
    .bus   (bus)
  );

  // requester-side drive, index 0=PPU 1=CPU 2=loader
  logic              req[3];
  logic [ADDR_W-1:0] addr[3];
  logic              we[3];
  logic [7:0]        wdata[3];
  logic              pending[3];
  int                auto_rate[3];

  assign bus.ppu_req = req[0];  assign bus.ppu_addr = addr[0];
  assign bus.ppu_we  = we[0];   assign bus.ppu_wdata = wdata[0];
  assign bus.cpu_req = req[1];  assign bus.cpu_addr = addr[1];
  assign bus.cpu_we  = we[1];   assign bus.cpu_wdata = wdata[1];
  assign bus.ldr_req = req[2];  assign bus.ldr_addr = addr[2];
  assign bus.ldr_we  = we[2];   assign bus.ldr_wdata = wdata[2];

  logic [7:0] dmem[int];
  logic [7:0] rmem[int];

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 37 + 11) & 255);
  endfunction

  function automatic logic [7:0] dread(input logic [ADDR_W-1:0] a);
    int k;
    k = int'(a);
    return dmem.exists(k) ? dmem[k] : init_val(k);
  endfunction

  function automatic logic [7:0] rread(input logic [ADDR_W-1:0] a);
    int k;
    k = int'(a);
    return rmem.exists(k) ? rmem[k] : init_val(k);
  endfunction

  // external memory: read data presented mid-cycle while ce is high
  always @(negedge clk_25) begin
    if (bus.mem_ce) begin
      if (bus.mem_we) dmem[int'(bus.mem_addr)] = bus.mem_wdata;
      else bus.mem_rdata = dread(bus.mem_addr);
    end
  end

  int checks   = 0;
  int failures = 0;

  // transaction-level model
  int                cyc = 0;
  int                free_at = 1;
  int                starve = 0;
  logic              act_valid = 1'b0;
  int                act_port = 0;
  int                act_start = 0;
  logic [ADDR_W-1:0] act_addr;
  logic              act_we;
  logic [7:0]        act_wdata;
  logic [7:0]        act_rd;
  logic [7:0]        exp_rd[3];
  int                obs_q[$];

  function automatic logic ack_of(input int p);
    case (p)
      0:       return bus.ppu_ack;
      1:       return bus.cpu_ack;
      default: return bus.ldr_ack;
    endcase
  endfunction

  function automatic logic [7:0] rd_of(input int p);
    case (p)
      0:       return bus.ppu_rdata;
      1:       return bus.cpu_rdata;
      default: return bus.ldr_rdata;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int p, input logic [ADDR_W-1:0] a, input logic w, input logic [7:0] d);
    addr[p] = a;
    we[p] = w;
    wdata[p] = d;
    req[p] = 1'b1;
    pending[p] = 1'b1;
  endtask

  task automatic step();
    int   w;
    logic ce_e, busy_e;
    @(posedge clk_25);
    cyc++;
    if (cyc == free_at) begin
      if (!req[1]) starve = 0;
      w = -1;
      if (req[1] && starve == MAXS) w = 1;
      else if (req[0])              w = 0;
      else if (req[1])              w = 1;
      else if (req[2])              w = 2;
      if (w == 0 && req[1]) starve = (starve < MAXS) ? starve + 1 : MAXS;
      if (w == 1) starve = 0;
      if (w >= 0) begin
        act_valid = 1'b1;
        act_port  = w;
        act_start = cyc;
        act_addr  = addr[w];
        act_we    = we[w];
        act_wdata = wdata[w];
        if (act_we) rmem[int'(act_addr)] = act_wdata;
        else act_rd = rread(act_addr);
        free_at = cyc + WAIT + 2;
      end else begin
        free_at = cyc + 1;
      end
    end
    @(negedge clk_25);
    ce_e   = act_valid && cyc >= act_start && cyc < act_start + WAIT;
    busy_e = act_valid && cyc >= act_start && cyc <= act_start + WAIT;
    if (act_valid && cyc == act_start + WAIT && !act_we) exp_rd[act_port] = act_rd;
    chk("mem_ce", 32'(bus.mem_ce), 32'(ce_e));
    chk("mem_we", 32'(bus.mem_we), 32'(ce_e && act_we));
    chk("busy", 32'(bus.busy), 32'(busy_e));
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("ack%0d", p), 32'(ack_of(p)),
          32'(act_valid && cyc == act_start + WAIT && act_port == p));
      chk($sformatf("rdata%0d", p), 32'(rd_of(p)), 32'(exp_rd[p]));
    end
    if (ce_e) chk("mem_addr", 32'(bus.mem_addr), 32'(act_addr));
    if (ce_e && act_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(act_wdata));
    for (int p = 0; p < 3; p++) begin
      if (ack_of(p)) begin
        obs_q.push_back(p);
        pending[p] = 1'b0;
        req[p] = 1'b0;
      end else if (!pending[p] && auto_rate[p] > 0 && int'($urandom_range(0, 99)) < auto_rate[p]) begin
        new_req(p, ADDR_W'($urandom_range(0, 31)) | (ADDR_W'($urandom_range(0, 3)) << 16),
                1'($urandom_range(0, 1)), 8'($urandom));
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pending[0] || pending[1] || pending[2] ||
            (act_valid && cyc < act_start + WAIT + 1)) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < 3; p++) begin
      req[p] = 1'b0; addr[p] = '0; we[p] = 1'b0; wdata[p] = '0;
      pending[p] = 1'b0; auto_rate[p] = 0; exp_rd[p] = 8'h00;
    end
    dmem[32'h08000] = 8'hA5;
    rmem[32'h08000] = 8'hA5;

    #1;
    chk("rst_mem_ce", 32'(bus.mem_ce), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_acks", 32'({bus.ppu_ack, bus.cpu_ack, bus.ldr_ack}), 32'd0);
    chk("rst_rdatas", 32'({bus.ppu_rdata, bus.cpu_rdata, bus.ldr_rdata}), 32'd0);
    @(negedge clk_25);
    rst = 1'b0;

    // single CPU read
    obs_q.delete();
    new_req(1, 18'h08000, 1'b0, 8'h00);
    drain(50);
    chk("t1_count", 32'(obs_q.size()), 32'd1);
    chk("t1_port", 32'(obs_q[0]), 32'd1);
    repeat (3) step();
    chk("t1_rdata_held", 32'(bus.cpu_rdata), 32'hA5);

    // loader write
    obs_q.delete();
    new_req(2, 18'h00010, 1'b1, 8'h3C);
    drain(50);
    chk("t2_port", 32'(obs_q[0]), 32'd2);
    chk("t2_ldr_rdata", 32'(bus.ldr_rdata), 32'd0);
    chk("t2_mem_written", 32'(dread(18'h00010)), 32'h3C);

    // simultaneous PPU + CPU
    obs_q.delete();
    new_req(0, 18'h00100, 1'b0, 8'h00);
    new_req(1, 18'h00010, 1'b0, 8'h00);
    drain(50);
    chk("t3_count", 32'(obs_q.size()), 32'd2);
    chk("t3_first", 32'(obs_q[0]), 32'd0);
    chk("t3_second", 32'(obs_q[1]), 32'd1);
    chk("t3_cpu_rdata", 32'(bus.cpu_rdata), 32'h3C);

    // PPU saturating the bus with CPU waiting
    obs_q.delete();
    auto_rate[0] = 100;
    auto_rate[1] = 100;
    for (int n = 0; n < 200 && obs_q.size() < 8; n++) step();
    auto_rate[0] = 0;
    auto_rate[1] = 0;
    drain(50);
    chk("t4_count_ge8", 32'(obs_q.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t4_grant%0d", i), 32'(obs_q[i]), 32'((i % 4 == 3) ? 1 : 0));

    // CPU arriving while the loader's access is in flight
    obs_q.delete();
    new_req(2, 18'h00020, 1'b0, 8'h00);
    step();
    step();
    new_req(1, 18'h00030, 1'b0, 8'h00);
    drain(50);
    chk("t5_first", 32'(obs_q[0]), 32'd2);
    chk("t5_second", 32'(obs_q[1]), 32'd1);

    // reset in the middle of an access
    obs_q.delete();
    new_req(1, 18'h00123, 1'b0, 8'h00);
    step();
    chk("t6_in_access", 32'(bus.mem_ce), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("t6_ce_drop", 32'(bus.mem_ce), 32'd0);
    chk("t6_we_drop", 32'(bus.mem_we), 32'd0);
    chk("t6_busy_drop", 32'(bus.busy), 32'd0);
    for (int p = 0; p < 3; p++) begin
      req[p] = 1'b0;
      pending[p] = 1'b0;
      exp_rd[p] = 8'h00;
    end
    repeat (2) @(posedge clk_25);
    @(negedge clk_25);
    chk("t6_no_ack", 32'({bus.ppu_ack, bus.cpu_ack, bus.ldr_ack}), 32'd0);
    chk("t6_cpu_rdata_cleared", 32'(bus.cpu_rdata), 32'd0);
    rst = 1'b0;
    act_valid = 1'b0;
    starve = 0;
    free_at = cyc + 1;
    new_req(1, 18'h08000, 1'b0, 8'h00);
    drain(50);
    chk("t6_after_count", 32'(obs_q.size()), 32'd1);
    chk("t6_after_rdata", 32'(bus.cpu_rdata), 32'hA5);

    // random mixed traffic
    auto_rate[0] = 35;
    auto_rate[1] = 25;
    auto_rate[2] = 20;
    repeat (1500) step();
    auto_rate[0] = 0;
    auto_rate[1] = 0;
    auto_rate[2] = 0;
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
